pulse_to_level: RTL and testbench
=================================

Name: pulse_to_level

Overview:
- Inverse of the edge-to-pulse conversion already used in the design: takes single-cycle event pulses and presents each one as a held level request to a slower or level-sensitive consumer.
- Each request is held for a minimum width and, optionally, until the consumer acknowledges it. A guaranteed low gap follows, so the consumer's rising-edge detector sees every event.
- Pulses that arrive while a request is outstanding are counted and replayed in order.
- Used between core-clocked event sources (timer tick, IRQ strobe) and level-sensitive peripherals or the edge detectors on their inputs.

Parameters:
- MIN_WIDTH, 4: minimum cycles `level` stays high per event; must be >= 1.
- GAP_CYCLES, 2: cycles `level` stays low between replayed events; must be >= 1.
- COUNT_WIDTH, 2: width of the pending-event counter; it saturates at 2^COUNT_WIDTH-1.
- REQUIRE_ACK, 1: 1 = release needs `ack`; 0 = `ack` is ignored and release happens on width only.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- pulse  in  1  single-cycle event strobe; every high cycle is one event.
- ack  in  1  consumer acknowledge; sampled only in ASSERT.
- clear_overflow  in  1  synchronous clear of `overflow`.
- level  out  1  held request level to the consumer.
- pending  out  COUNT_WIDTH  events queued behind the current request.
- overflow  out  1  sticky flag: an event was dropped because `pending` was saturated.

Behaviour:
- Reset (async, immediate): state=IDLE; level=0, pending=0, overflow=0; internal width_cnt, gap_cnt and ack_seen cleared. Reset mid-ASSERT or mid-GAP drops the request and all queued events.
- All outputs are registered.
- States: IDLE, ASSERT, GAP.
- IDLE:
  - level=0.
  - pulse=1 at an edge: go to ASSERT, level<=1, width_cnt<=MIN_WIDTH-1, ack_seen<=0.
  - Latency is one cycle: a pulse sampled at the end of cycle N gives level high from cycle N+1.
- ASSERT:
  - level=1.
  - Each edge: if width_cnt!=0, width_cnt decrements; ack_seen<=ack_seen|ack.
  - Release condition: width_cnt==0 AND (ack_seen OR ack OR REQUIRE_ACK==0).
  - On release: level<=0, go to GAP, gap_cnt<=GAP_CYCLES-1.
  - An ack that arrives before the width expires is remembered. An ack in IDLE or GAP is ignored.
- GAP:
  - level=0.
  - While gap_cnt!=0, it decrements.
  - When gap_cnt==0 and pending!=0: go to ASSERT (same loads as from IDLE); pending <= pending-1, plus 1 if pulse is high the same cycle.
  - When gap_cnt==0, pending==0 and pulse=1: go to ASSERT, consuming that pulse directly.
  - Otherwise go to IDLE.
- Pending counter:
  - pulse in ASSERT, or in GAP when not consumed directly, increments pending.
  - A simultaneous increment and decrement leaves pending unchanged.
  - Increment at 2^COUNT_WIDTH-1 holds the value and sets overflow<=1; that event is lost.
- Overflow:
  - Sticky until clear_overflow=1.
  - If a set and a clear happen in the same cycle, the set wins.
- Per-event timing: level high for max(MIN_WIDTH, cycles-to-ack+1) cycles, then low for exactly GAP_CYCLES cycles before any replay.
- Events are never merged or reordered; only saturation drops them.

Decomposition:
- Shared package: state enum typedef (IDLE/ASSERT/GAP).
- No sub-module: a single FSM with three counters.
- The existing edge-to-pulse block is the natural producer upstream. The consumer's own edge detector is downstream.

Test Plan:
All cases use default parameters with ack held 1, unless stated.
1. Single pulse in cycle 0 -> level=1 in cycles 1-4, 0 from cycle 5; pending stays 0; overflow 0.
2. Late ack: single pulse in cycle 0, ack=0 until a one-cycle ack in cycle 8 -> level=1 in cycles 1-8, 0 from cycle 9. Repeat with ack=1 only in cycle 1 -> level 1-4, showing the early ack is remembered.
3. Queued replay: pulses in cycles 0,1,2 -> pending 1 in cycle 2, 2 in cycle 3. Level high in cycles 1-4, low 5-6, high 7-10 (pending=1), low 11-12, high 13-16 (pending=0), then IDLE.
4. Saturation: pulses in cycles 0-4 -> pending reaches 3 in cycle 4. The pulse in cycle 4 is dropped and overflow=1 from cycle 5. clear_overflow in cycle 7 -> overflow=0 in cycle 8. A simultaneous new overflow and clear -> overflow stays 1.
5. Reset mid-operation: pulses in cycles 0-1, reset asserted in cycle 2 -> level, pending and overflow are 0 immediately. After release, a pulse in cycle 5 -> level high in cycles 6-9.
6. REQUIRE_ACK=0, MIN_WIDTH=1, GAP_CYCLES=1, ack=0, pulses in cycles 0-3 -> level alternates: high 1, low 2, high 3, low 4, high 5, low 6, high 7; pending peaks at 2; no overflow.

Source files
------------

// File: rtl/pulse_to_level_pkg.sv
// pulse_to_level_pkg
//   Shared types for the pulse_to_level block.
//   state_t : request FSM state (IDLE / ASSERT / GAP).
package pulse_to_level_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_to_level.sv
// pulse_to_level
//   Turns single-cycle event pulses into held level requests for a slower or
//   level-sensitive consumer. Each request stays high for at least MIN_WIDTH
//   cycles (and, with REQUIRE_ACK, until ack is seen), then drops for exactly
//   GAP_CYCLES cycles so a downstream rising-edge detector sees every event.
//   Pulses arriving while a request is outstanding are counted and replayed.
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   pulse          in   event strobe, every high cycle is one event
//   ack            in   consumer acknowledge, only looked at while asserting
//   clear_overflow in   synchronous clear of overflow
//   level          out  held request level
//   pending        out  events queued behind the current request
//   overflow       out  sticky: an event was dropped at pending saturation
//
// States
//   state  | meaning
//   IDLE   | no request outstanding, level low
//   ASSERT | request held high, waiting for width and ack
//   GAP    | level forced low before the next replay or idle
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int MIN_WIDTH   = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int COUNT_WIDTH = 2,
  parameter int REQUIRE_ACK = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pulse,
  input  logic                   ack,
  input  logic                   clear_overflow,
  output logic                   level,
  output logic [COUNT_WIDTH-1:0] pending,
  output logic                   overflow
);

  // Counters hold value-1 so a width/gap of 1 still needs a 1-bit register.
  localparam int WW = (MIN_WIDTH  > 1) ? $clog2(MIN_WIDTH)  : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WW-1:0]          WIDTH_LOAD = WW'(MIN_WIDTH - 1);
  localparam logic [GW-1:0]          GAP_LOAD   = GW'(GAP_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] PEND_MAX   = '1;

  state_t                 state_q, state_d;
  logic [WW-1:0]          width_q, width_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   ack_seen_q, ack_seen_d;
  logic                   level_q, level_d;
  logic [COUNT_WIDTH-1:0] pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   inc, dec, ovf_set;
  logic                   ack_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      width_q    <= '0;
      gap_q      <= '0;
      ack_seen_q <= 1'b0;
      level_q    <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      gap_q      <= gap_d;
      ack_seen_q <= ack_seen_d;
      level_q    <= level_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    gap_d      = gap_q;
    ack_seen_d = ack_seen_q;
    level_d    = level_q;
    pend_d     = pend_q;
    inc        = 1'b0;
    dec        = 1'b0;
    ovf_set    = 1'b0;
    ack_ok     = ack_seen_q | ack | (REQUIRE_ACK == 0);

    case (state_q)
      IDLE: begin
        if (pulse) begin
          state_d    = ASSERT;
          level_d    = 1'b1;
          width_d    = WIDTH_LOAD;
          ack_seen_d = 1'b0;
        end
      end
      ASSERT: begin
        if (width_q != '0) width_d = width_q - 1'b1;
        ack_seen_d = ack_seen_q | ack;
        inc        = pulse;
        if (width_q == '0 && ack_ok) begin
          state_d = GAP;
          level_d = 1'b0;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
          inc   = pulse;
        end else if (pend_q != '0) begin
          // Replay the oldest queued event; a same-cycle pulse joins the queue.
          state_d    = ASSERT;
          level_d    = 1'b1;
          width_d    = WIDTH_LOAD;
          ack_seen_d = 1'b0;
          dec        = 1'b1;
          inc        = pulse;
        end else if (pulse) begin
          state_d    = ASSERT;
          level_d    = 1'b1;
          width_d    = WIDTH_LOAD;
          ack_seen_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
      end
    endcase

    if (inc && !dec) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + 1'b1;
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end

    // A new drop wins over a same-cycle clear.
    ovf_d = ovf_set | (ovf_q & ~clear_overflow);
  end

  assign level    = level_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_to_level.sv
module tb_pulse_to_level;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse = 1'b0;
  logic       ack = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       level_a, level_b, overflow_a, overflow_b;
  logic [1:0] pending_a, pending_b;

  always #5 clk = ~clk;

  pulse_to_level dut_a (
    .clk(clk), .reset(reset), .pulse(pulse), .ack(ack),
    .clear_overflow(clear_overflow),
    .level(level_a), .pending(pending_a), .overflow(overflow_a)
  );

  pulse_to_level #(.MIN_WIDTH(1), .GAP_CYCLES(1), .COUNT_WIDTH(2), .REQUIRE_ACK(0)) dut_b (
    .clk(clk), .reset(reset), .pulse(pulse), .ack(ack),
    .clear_overflow(clear_overflow),
    .level(level_b), .pending(pending_b), .overflow(overflow_b)
  );

  // Reference model built on absolute cycle timestamps of each request.
  typedef struct {
    bit active;
    int hi_start;
    int ack_at;
    int low_start;
    int pend;
    bit ovf;
  } model_t;

  typedef struct {
    int cyc;
    bit la; int pa; bit oa;
    bit lb; int pb; bit ob;
  } exp_t;

  model_t ma, mb;
  exp_t   q[$];
  int     cyc_s = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     done = 1'b0;

  function automatic model_t model_reset();
    model_t m;
    m.active = 0; m.hi_start = 0; m.ack_at = -1; m.low_start = -1;
    m.pend = 0; m.ovf = 0;
    return m;
  endfunction

  function automatic bit model_level(model_t m);
    return m.active && (m.low_start < 0);
  endfunction

  function automatic model_t model_step(model_t m, int c, bit p, bit a, bit co,
                                        int minw, int gapc, bit req, int maxp);
    bit enq = 0;
    bit set = 0;
    bit start = 0;
    if (!m.active) begin
      start = p;
    end else if (m.low_start < 0) begin
      if (a && m.ack_at < 0) m.ack_at = c;
      if (c >= m.hi_start + minw - 1 && (!req || m.ack_at >= 0)) m.low_start = c + 1;
      enq = p;
    end else if (c >= m.low_start + gapc - 1) begin
      if (m.pend > 0) begin
        m.pend--;
        start = 1;
        enq   = p;
      end else if (p) begin
        start = 1;
      end else begin
        m.active = 0;
      end
    end else begin
      enq = p;
    end
    if (start) begin
      m.active = 1; m.hi_start = c + 1; m.ack_at = -1; m.low_start = -1;
    end
    if (enq) begin
      if (m.pend == maxp) set = 1;
      else m.pend++;
    end
    m.ovf = set ? 1'b1 : (co ? 1'b0 : m.ovf);
    return m;
  endfunction

  function automatic exp_t make_exp(int c, model_t a, model_t b);
    exp_t e;
    e.cyc = c;
    e.la = model_level(a); e.pa = a.pend; e.oa = a.ovf;
    e.lb = model_level(b); e.pb = b.pend; e.ob = b.ovf;
    return e;
  endfunction

  // Drives the inputs of the current cycle and queues the outputs expected next cycle.
  task automatic drive(input bit p, input bit a, input bit co, input bit r);
    pulse = p; ack = a; clear_overflow = co; reset = r;
    if (r) begin
      // Async reset clears outputs within this very cycle.
      if (q.size() > 0 && q[$].cyc == cyc_s) void'(q.pop_back());
      ma = model_reset();
      mb = model_reset();
      q.push_back(make_exp(cyc_s, ma, mb));
    end else begin
      ma = model_step(ma, cyc_s, p, a, co, 4, 2, 1'b1, 3);
      mb = model_step(mb, cyc_s, p, a, co, 1, 1, 1'b0, 3);
    end
    q.push_back(make_exp(cyc_s + 1, ma, mb));
    @(posedge clk); #1;
    cyc_s++;
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) drive(1'b0, a, 1'b0, 1'b0);
  endtask

  // Monitor: one expected tuple per cycle per instance.
  initial begin : monitor
    int   cyc_m;
    exp_t e;
    cyc_m = 0;
    @(posedge clk); #2;
    while (!done) begin
      while (q.size() > 0 && q[0].cyc <= cyc_m) begin
        e = q.pop_front();
        if (e.cyc < cyc_m) begin
          miscompares++;
          $display("FAIL stale_expect cycle %0d: entry for cycle %0d never compared", cyc_m, e.cyc);
          continue;
        end
        vectors++;
        if (level_a !== e.la || int'(pending_a) != e.pa || overflow_a !== e.oa) begin
          miscompares++;
          $display("FAIL dut_a cycle %0d: level/pending/overflow got %0b/%0d/%0b want %0b/%0d/%0b",
                   cyc_m, level_a, pending_a, overflow_a, e.la, e.pa, e.oa);
        end
        vectors++;
        if (level_b !== e.lb || int'(pending_b) != e.pb || overflow_b !== e.ob) begin
          miscompares++;
          $display("FAIL dut_b cycle %0d: level/pending/overflow got %0b/%0d/%0b want %0b/%0d/%0b",
                   cyc_m, level_b, pending_b, overflow_b, e.lb, e.pb, e.ob);
        end
      end
      @(posedge clk); #2;
      cyc_m++;
    end
  end

  initial begin : stimulus
    ma = model_reset();
    mb = model_reset();
    @(posedge clk); #1;

    drive(0, 1, 0, 1);
    drive(0, 1, 0, 1);
    idle(2, 1);

    // single pulse, ack held high
    drive(1, 1, 0, 0);
    idle(8, 1);

    // late ack in cycle 8
    drive(1, 0, 0, 0);
    idle(7, 0);
    drive(0, 1, 0, 0);
    idle(6, 0);

    // early ack in cycle 1 only
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    idle(10, 0);

    // queued replay
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
    idle(18, 1);

    // saturation, clear in cycle 7
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);
    idle(2, 1);
    drive(0, 1, 1, 0);
    idle(2, 1);
    // new drop coinciding with clear
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    idle(40, 1);
    drive(0, 1, 1, 0);
    idle(2, 1);

    // reset mid-operation
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 1);
    idle(2, 1);
    drive(1, 1, 0, 0);
    idle(8, 1);

    // four back-to-back pulses with ack low
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0);
    idle(10, 0);
    idle(40, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 5,  $urandom_range(0, 199) == 0);
    end

    idle(60, 1);
    done = 1'b1;
    @(posedge clk); #3;
    // Only the entry for the cycle just entered may remain.
    if (q.size() > 1) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want at most 1", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
